branch_predictor: RTL and testbench

- Fetch-stage dynamic branch predictor: 2-bit saturating-counter BHT plus direct-mapped BTB.
- Carries each prediction down the F→D→E pipeline and checks it against the branch outcome resolved in Execute.
- Generates the Eval_branch mispredict request that the hazard unit turns into FlushD/FlushE, and supplies the corrected fetch PC.
- Keeps branch and mispredict counters for performance measurement.

---
 rtl/branch_predictor.sv | 149 ++++++++++++++
 tb/tb_branch_predictor.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Fetch-stage dynamic branch predictor: 2-bit saturating BHT plus direct-mapped BTB.
// Predictions ride the F->D->E pipeline and are checked against the outcome resolved in E.
module branch_predictor #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned IDX_BITS = 6,
  parameter int unsigned CNT_BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [XLEN-1:0]     PCF,
  input  logic                StallF,
  input  logic                StallD,
  input  logic                FlushD,
  input  logic                FlushE,
  output logic                PredTakenF,
  output logic [XLEN-1:0]     PredTargetF,
  input  logic                BranchE,
  input  logic                TakenE,
  input  logic [XLEN-1:0]     TargetE,
  input  logic [XLEN-1:0]     PCE,
  output logic                Eval_branch,
  output logic [XLEN-1:0]     PCRedirectE,
  output logic [CNT_BITS-1:0] BranchCount,
  output logic [CNT_BITS-1:0] MispredCount
);
  localparam int Entries = 2 ** IDX_BITS;
  localparam int TagBits = XLEN - IDX_BITS - 2;

  logic [1:0]         r_bht       [Entries];
  logic               r_btb_valid [Entries];
  logic [TagBits-1:0] r_btb_tag   [Entries];
  logic [XLEN-1:0]    r_btb_tgt   [Entries];

  logic                r_pv_d, r_pt_d, r_pv_e, r_pt_e;
  logic [XLEN-1:0]     r_pg_d, r_pg_e;
  logic [CNT_BITS-1:0] r_branch_cnt, r_mispred_cnt;

  logic [IDX_BITS-1:0] w_idx_f, w_idx_e;
  logic [TagBits-1:0]  w_tag_f, w_tag_e;
  logic                w_hit_f, w_mispred, w_upd, w_btb_wr, w_alias_clr;
  logic                w_unused;

  // StallF has no effect on predictor state; the fetch PC itself is held upstream.
  assign w_unused = StallF;

  assign w_idx_f = PCF[IDX_BITS+1:2];
  assign w_tag_f = PCF[XLEN-1:IDX_BITS+2];
  assign w_idx_e = PCE[IDX_BITS+1:2];
  assign w_tag_e = PCE[XLEN-1:IDX_BITS+2];

  assign w_hit_f     = r_btb_valid[w_idx_f] && (r_btb_tag[w_idx_f] == w_tag_f);
  assign PredTakenF  = w_hit_f && r_bht[w_idx_f][1];
  assign PredTargetF = w_hit_f ? r_btb_tgt[w_idx_f] : '0;

  always_comb begin
    w_mispred = 1'b0;
    if (BranchE) begin
      w_mispred = (r_pt_e != TakenE) || (r_pt_e && TakenE && (r_pg_e != TargetE));
    end else begin
      // Predicted taken on a non-branch means the BTB entry aliased.
      w_mispred = r_pt_e;
    end
  end

  assign Eval_branch = r_pv_e && w_mispred;
  assign PCRedirectE = (BranchE && TakenE) ? TargetE : PCE + XLEN'(4);

  assign w_upd       = r_pv_e && BranchE;
  assign w_btb_wr    = w_upd && TakenE;
  assign w_alias_clr = r_pv_e && !BranchE && r_pt_e && (r_btb_tag[w_idx_e] == w_tag_e);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < Entries; i++) begin
        r_bht[i]       <= 2'b01;
        r_btb_valid[i] <= 1'b0;
      end
    end else if (w_upd) begin
      if (TakenE && (r_bht[w_idx_e] != 2'b11)) begin
        r_bht[w_idx_e] <= r_bht[w_idx_e] + 2'd1;
      end else if (!TakenE && (r_bht[w_idx_e] != 2'b00)) begin
        r_bht[w_idx_e] <= r_bht[w_idx_e] - 2'd1;
      end
      if (TakenE) begin
        r_btb_valid[w_idx_e] <= 1'b1;
      end
    end else if (w_alias_clr) begin
      r_btb_valid[w_idx_e] <= 1'b0;
    end
  end

  // Tag and target storage is qualified by the valid bits, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_btb_wr) begin
      r_btb_tag[w_idx_e] <= w_tag_e;
      r_btb_tgt[w_idx_e] <= TargetE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pv_d <= 1'b0;
      r_pt_d <= 1'b0;
      r_pg_d <= '0;
    end else if (FlushD) begin
      r_pv_d <= 1'b0;
      r_pt_d <= 1'b0;
      r_pg_d <= '0;
    end else if (!StallD) begin
      r_pv_d <= 1'b1;
      r_pt_d <= PredTakenF;
      r_pg_d <= PredTargetF;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pv_e <= 1'b0;
      r_pt_e <= 1'b0;
      r_pg_e <= '0;
    end else if (FlushE) begin
      r_pv_e <= 1'b0;
      r_pt_e <= 1'b0;
      r_pg_e <= '0;
    end else begin
      r_pv_e <= r_pv_d;
      r_pt_e <= r_pt_d;
      r_pg_e <= r_pg_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (w_upd) begin
        r_branch_cnt <= r_branch_cnt + CNT_BITS'(1);
      end
      if (Eval_branch) begin
        r_mispred_cnt <= r_mispred_cnt + CNT_BITS'(1);
      end
    end
  end

  assign BranchCount  = r_branch_cnt;
  assign MispredCount = r_mispred_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor: training, retargeting, stalls,
// aliasing and asynchronous reset, with hand-computed expectations.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] PCF = '0;
  logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, FlushE = 1'b0;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        BranchE = 1'b0, TakenE = 1'b0;
  logic [31:0] TargetE = '0, PCE = '0;
  logic        Eval_branch;
  logic [31:0] PCRedirectE, BranchCount, MispredCount;

  int          n_checks = 0;
  int          n_errors = 0;
  logic        p_taken;
  logic [31:0] p_tgt;

  branch_predictor #(.XLEN(32), .IDX_BITS(6), .CNT_BITS(32)) dut (
    .clk(clk), .rst(rst), .PCF(PCF), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .FlushE(FlushE), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF), .BranchE(BranchE),
    .TakenE(TakenE), .TargetE(TargetE), .PCE(PCE), .Eval_branch(Eval_branch),
    .PCRedirectE(PCRedirectE), .BranchCount(BranchCount), .MispredCount(MispredCount)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fetch pc into a clean pipe (E bubble during fetch), then move it to E with D flushed.
  task automatic do_fetch(input logic [31:0] pc, output logic taken, output logic [31:0] tgt);
    PCF = pc; StallD = 1'b0; FlushD = 1'b0; FlushE = 1'b1; BranchE = 1'b0; TakenE = 1'b0;
    #1;
    taken = PredTakenF;
    tgt   = PredTargetF;
    tick();
    PCF = '0; FlushD = 1'b1; FlushE = 1'b0;
    tick();
  endtask

  task automatic drive_e(input logic br, input logic tk, input logic [31:0] tgt,
                         input logic [31:0] pc);
    BranchE = br; TakenE = tk; TargetE = tgt; PCE = pc; FlushD = 1'b1; FlushE = 1'b1;
    #1;
  endtask

  task automatic retire();
    tick();
    BranchE = 1'b0; TakenE = 1'b0;
  endtask

  task automatic test_reset();
    PCF = 32'h100; FlushD = 1'b1; FlushE = 1'b1;
    #1;
    n_checks++;
    if (PredTakenF !== 1'b0) begin
      n_errors++; $display("FAIL reset_pred: got %0h want 0", PredTakenF);
    end
    n_checks++;
    if (PredTargetF !== 32'h0) begin
      n_errors++; $display("FAIL reset_tgt: got %0h want 0", PredTargetF);
    end
    n_checks++;
    if ({Eval_branch, BranchCount, MispredCount} !== 65'h0) begin
      n_errors++;
      $display("FAIL reset_state: eval=%0h bc=%0d mc=%0d want all 0",
               Eval_branch, BranchCount, MispredCount);
    end
  endtask

  task automatic test_first_taken();
    do_fetch(32'h100, p_taken, p_tgt);
    n_checks++;
    if (p_taken !== 1'b0) begin
      n_errors++; $display("FAIL first_pred: got %0h want 0", p_taken);
    end
    drive_e(1'b1, 1'b1, 32'h80, 32'h100);
    n_checks++;
    if ({Eval_branch, PCRedirectE} !== {1'b1, 32'h80}) begin
      n_errors++; $display("FAIL first_eval: got %0h/%0h want 1/80", Eval_branch, PCRedirectE);
    end
    retire();
    n_checks++;
    if ({BranchCount, MispredCount} !== {32'd1, 32'd1}) begin
      n_errors++; $display("FAIL first_cnt: got %0d/%0d want 1/1", BranchCount, MispredCount);
    end
  endtask

  // Three correct taken predictions (bht 10 -> 11 -> 11), then a not-taken (11 -> 10).
  task automatic test_train();
    for (int k = 0; k < 3; k++) begin
      do_fetch(32'h100, p_taken, p_tgt);
      n_checks++;
      if ({p_taken, p_tgt} !== {1'b1, 32'h80}) begin
        n_errors++; $display("FAIL train_pred%0d: got %0h/%0h want 1/80", k, p_taken, p_tgt);
      end
      drive_e(1'b1, 1'b1, 32'h80, 32'h100);
      n_checks++;
      if (Eval_branch !== 1'b0) begin
        n_errors++; $display("FAIL train_eval%0d: got %0h want 0", k, Eval_branch);
      end
      retire();
    end
    do_fetch(32'h100, p_taken, p_tgt);
    drive_e(1'b1, 1'b0, 32'h0, 32'h100);
    n_checks++;
    if ({Eval_branch, PCRedirectE} !== {1'b1, 32'h104}) begin
      n_errors++; $display("FAIL nt_eval: got %0h/%0h want 1/104", Eval_branch, PCRedirectE);
    end
    retire();
    n_checks++;
    if ({BranchCount, MispredCount} !== {32'd5, 32'd2}) begin
      n_errors++; $display("FAIL train_cnt: got %0d/%0d want 5/2", BranchCount, MispredCount);
    end
  endtask

  task automatic test_target_change();
    do_fetch(32'h100, p_taken, p_tgt);
    n_checks++;
    if ({p_taken, p_tgt} !== {1'b1, 32'h80}) begin
      n_errors++; $display("FAIL retgt_pred: got %0h/%0h want 1/80", p_taken, p_tgt);
    end
    drive_e(1'b1, 1'b1, 32'h90, 32'h100);
    n_checks++;
    if ({Eval_branch, PCRedirectE} !== {1'b1, 32'h90}) begin
      n_errors++; $display("FAIL retgt_eval: got %0h/%0h want 1/90", Eval_branch, PCRedirectE);
    end
    retire();
    do_fetch(32'h100, p_taken, p_tgt);
    n_checks++;
    if ({p_taken, p_tgt} !== {1'b1, 32'h90}) begin
      n_errors++; $display("FAIL retgt_new: got %0h/%0h want 1/90", p_taken, p_tgt);
    end
    drive_e(1'b1, 1'b1, 32'h90, 32'h100);
    n_checks++;
    if (Eval_branch !== 1'b0) begin
      n_errors++; $display("FAIL retgt_ok: got %0h want 0", Eval_branch);
    end
    retire();
  endtask

  // Index 1 (pc 0x204): saturate at 00, then one taken brings it only to 01.
  task automatic test_low_saturate();
    PCF = 32'h200; FlushD = 1'b1; FlushE = 1'b1;
    #1;
    n_checks++;
    if ({PredTakenF, PredTargetF} !== {1'b0, 32'h0}) begin
      n_errors++;
      $display("FAIL tag_miss: got %0h/%0h want 0/0", PredTakenF, PredTargetF);
    end
    for (int k = 0; k < 2; k++) begin
      do_fetch(32'h204, p_taken, p_tgt);
      drive_e(1'b1, 1'b0, 32'h0, 32'h204);
      n_checks++;
      if ({Eval_branch, PCRedirectE} !== {1'b0, 32'h208}) begin
        n_errors++;
        $display("FAIL sat_nt%0d: got %0h/%0h want 0/208", k, Eval_branch, PCRedirectE);
      end
      retire();
    end
    do_fetch(32'h204, p_taken, p_tgt);
    drive_e(1'b1, 1'b1, 32'h300, 32'h204);
    retire();
    do_fetch(32'h204, p_taken, p_tgt);
    n_checks++;
    if ({p_taken, p_tgt} !== {1'b0, 32'h300}) begin
      n_errors++; $display("FAIL sat_pred: got %0h/%0h want 0/300", p_taken, p_tgt);
    end
    drive_e(1'b1, 1'b1, 32'h300, 32'h204);
    n_checks++;
    if ({Eval_branch, PCRedirectE} !== {1'b1, 32'h300}) begin
      n_errors++; $display("FAIL sat_eval: got %0h/%0h want 1/300", Eval_branch, PCRedirectE);
    end
    retire();
    n_checks++;
    if ({BranchCount, MispredCount} !== {32'd11, 32'd5}) begin
      n_errors++; $display("FAIL sat_cnt: got %0d/%0d want 11/5", BranchCount, MispredCount);
    end
  endtask

  task automatic test_stall_bubble();
    PCF = 32'h100; StallD = 1'b0; FlushD = 1'b0; FlushE = 1'b1; BranchE = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      PCF = 32'h204; StallD = 1'b1; FlushD = 1'b0; FlushE = 1'b1;
      BranchE = 1'b1; TakenE = 1'b0; TargetE = 32'h0; PCE = 32'h100;
      #1;
      n_checks++;
      if (Eval_branch !== 1'b0) begin
        n_errors++; $display("FAIL stall_eval%0d: got %0h want 0", k, Eval_branch);
      end
      tick();
    end
    n_checks++;
    if ({BranchCount, MispredCount} !== {32'd11, 32'd5}) begin
      n_errors++; $display("FAIL stall_cnt: got %0d/%0d want 11/5", BranchCount, MispredCount);
    end
    StallD = 1'b0; FlushD = 1'b1; FlushE = 1'b0; BranchE = 1'b0;
    tick();
    drive_e(1'b1, 1'b1, 32'h90, 32'h100);
    n_checks++;
    if (Eval_branch !== 1'b0) begin
      n_errors++; $display("FAIL stall_held: got %0h want 0", Eval_branch);
    end
    retire();
    // Redirect wraps at the top of the address space; bubble in E keeps Eval low.
    drive_e(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFC);
    n_checks++;
    if ({Eval_branch, PCRedirectE} !== {1'b0, 32'h0}) begin
      n_errors++; $display("FAIL wrap: got %0h/%0h want 0/0", Eval_branch, PCRedirectE);
    end
    BranchE = 1'b0;
    n_checks++;
    if ({BranchCount, MispredCount} !== {32'd12, 32'd5}) begin
      n_errors++; $display("FAIL release_cnt: got %0d/%0d want 12/5", BranchCount, MispredCount);
    end
  endtask

  task automatic test_alias();
    do_fetch(32'h100, p_taken, p_tgt);
    drive_e(1'b0, 1'b0, 32'h0, 32'h100);
    n_checks++;
    if ({Eval_branch, PCRedirectE} !== {1'b1, 32'h104}) begin
      n_errors++; $display("FAIL alias_eval: got %0h/%0h want 1/104", Eval_branch, PCRedirectE);
    end
    retire();
    n_checks++;
    if ({BranchCount, MispredCount} !== {32'd12, 32'd6}) begin
      n_errors++; $display("FAIL alias_cnt: got %0d/%0d want 12/6", BranchCount, MispredCount);
    end
    PCF = 32'h100; FlushD = 1'b1; FlushE = 1'b1;
    #1;
    n_checks++;
    if ({PredTakenF, PredTargetF} !== {1'b0, 32'h0}) begin
      n_errors++; $display("FAIL alias_inval: got %0h/%0h want 0/0", PredTakenF, PredTargetF);
    end
  endtask

  task automatic test_reset_mid();
    do_fetch(32'h204, p_taken, p_tgt);
    n_checks++;
    if ({p_taken, p_tgt} !== {1'b1, 32'h300}) begin
      n_errors++; $display("FAIL mid_pred: got %0h/%0h want 1/300", p_taken, p_tgt);
    end
    drive_e(1'b1, 1'b0, 32'h0, 32'h204);
    n_checks++;
    if (Eval_branch !== 1'b1) begin
      n_errors++; $display("FAIL mid_pending: got %0h want 1", Eval_branch);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({Eval_branch, BranchCount, MispredCount} !== 65'h0) begin
      n_errors++;
      $display("FAIL mid_reset: eval=%0h bc=%0d mc=%0d want all 0",
               Eval_branch, BranchCount, MispredCount);
    end
    #2;
    rst = 1'b1; BranchE = 1'b0; PCF = 32'h204;
    #1;
    n_checks++;
    if ({PredTakenF, PredTargetF} !== {1'b0, 32'h0}) begin
      n_errors++; $display("FAIL mid_lookup: got %0h/%0h want 0/0", PredTakenF, PredTargetF);
    end
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b1;
    test_reset();
    test_first_taken();
    test_train();
    test_target_change();
    test_low_saturate();
    test_stall_bubble();
    test_alias();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
